// File: rtl/seg7_pkg.sv
// Shared types and widths for the seven-segment scan controller.
package seg7_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned SLOTS  = 1 << IDX_W;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  // Index of the final digit in a scan of num digits.
  function automatic logic [IDX_W-1:0] last_idx(input int unsigned num);
    return IDX_W'(num - 1);
  endfunction

endpackage

// File: rtl/seg7_dwell_timer.sv
// Dwell counter: load clears the count and arms a terminal count of load_val-1.
module seg7_dwell_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         count_en,
  output logic         tc_c
);

  logic [W-1:0] count;
  logic [W-1:0] last;

  assign tc_c = (count == last);

  // Count saturates at terminal count until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      last  <= '0;
    end else if (load) begin
      count <= '0;
      last  <= load_val - W'(1);
    end else if (count_en && !tc_c) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed scan controller: per-digit code store, dwell/blank sequencing,
// and a write port that never disturbs the digit currently lit.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SHOW_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [CODE_W-1:0]     wr_data,
  input  logic [NUM_DIGITS-1:0] blank_mask,
  output logic [CODE_W-1:0]     code,
  output logic [NUM_DIGITS-1:0] digit_en,
  output logic                  frame_done,
  output logic                  wr_err
);

  localparam int unsigned MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
  localparam int unsigned TIMER_W = $clog2(MAX_CYC + 1);

  state_t               state;
  state_t               state_nxt_c;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_nxt_c;
  logic                 wrap_c;
  logic                 load_c;
  logic                 tc_c;
  logic [TIMER_W-1:0]   load_val_c;
  logic                 xfer_c;
  logic                 wr_ok_c;
  logic [CODE_W-1:0]    show_code_c;
  logic [SLOTS-1:0]     sel_c;
  logic [SLOTS-1:0]     mask_ext_c;
  logic [CODE_W-1:0]    mem [SLOTS];

  // Writes are only held off for the digit that is lit right now.
  assign wr_ready = rst_n && ((state != SHOW) || (wr_idx != idx));
  assign xfer_c   = wr_valid && wr_ready;
  assign wr_ok_c  = ({1'b0, wr_idx} < (IDX_W + 1)'(NUM_DIGITS));

  // Next-state and slot sequencing.
  always_comb begin
    state_nxt_c = state;
    idx_nxt_c   = idx;
    wrap_c      = 1'b0;
    if (!en) begin
      state_nxt_c = OFF;
      idx_nxt_c   = '0;
    end else begin
      case (state)
        OFF: begin
          state_nxt_c = SHOW;
          idx_nxt_c   = '0;
        end
        SHOW: begin
          if (tc_c) state_nxt_c = BLANK;
        end
        BLANK: begin
          if (tc_c) begin
            state_nxt_c = SHOW;
            if (idx == last_idx(NUM_DIGITS)) begin
              idx_nxt_c = '0;
              wrap_c    = 1'b1;
            end else begin
              idx_nxt_c = idx + IDX_W'(1);
            end
          end
        end
        default: begin
          state_nxt_c = OFF;
          idx_nxt_c   = '0;
        end
      endcase
    end
  end

  // Timer restarts on every state change and is held cleared while off.
  assign load_c     = (state_nxt_c != state) || (state == OFF);
  assign load_val_c = (state_nxt_c == BLANK) ? TIMER_W'(BLANK_CYCLES) : TIMER_W'(SHOW_CYCLES);

  seg7_dwell_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_c),
    .load_val (load_val_c),
    .count_en (1'b1),
    .tc_c     (tc_c)
  );

  // A write landing on the same edge that lights its digit is forwarded.
  assign show_code_c = (xfer_c && wr_ok_c && (wr_idx == idx_nxt_c)) ? wr_data : mem[idx_nxt_c];
  assign sel_c       = SLOTS'(1) << idx_nxt_c;
  assign mask_ext_c  = SLOTS'(blank_mask);

  // State, code store and registered outputs; frame_done marks the first
  // cycle of digit 0 after a full frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= OFF;
      idx        <= '0;
      code       <= '0;
      digit_en   <= '0;
      frame_done <= 1'b0;
      wr_err     <= 1'b0;
      for (int i = 0; i < int'(SLOTS); i++) mem[i] <= '0;
    end else begin
      state      <= state_nxt_c;
      idx        <= idx_nxt_c;
      frame_done <= wrap_c;
      wr_err     <= xfer_c && !wr_ok_c;
      if (xfer_c && wr_ok_c) mem[wr_idx] <= wr_data;
      if (state_nxt_c == SHOW) begin
        code     <= show_code_c;
        digit_en <= NUM_DIGITS'(sel_c & ~mask_ext_c);
      end else begin
        digit_en <= '0;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a slot/frame-position model predicts
// each cycle's outputs, a negedge monitor pops and compares them.
module tb_seg7_scan_ctrl;

  localparam int N     = 4;
  localparam int SC    = 4;
  localparam int BC    = 1;
  localparam int SLOT  = SC + BC;
  localparam int FRAME = N * SLOT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       wr_valid = 1'b0;
  logic [2:0] wr_idx = '0;
  logic [2:0] wr_data = '0;
  logic [3:0] blank_mask = '0;
  logic       wr_ready;
  logic [2:0] code;
  logic [3:0] digit_en;
  logic       frame_done;
  logic       wr_err;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (N),
    .SHOW_CYCLES  (SC),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .blank_mask (blank_mask),
    .code       (code),
    .digit_en   (digit_en),
    .frame_done (frame_done),
    .wr_err     (wr_err)
  );

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void timeout(string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endfunction

  // Reference model: scan position counted in cycles since enable.
  typedef struct {
    logic [3:0] de;
    logic [2:0] code;
    logic       fd;
    logic       err;
  } exp_t;

  exp_t       q[$];
  bit         m_on = 1'b0;
  int         m_pos = 0;
  logic [2:0] m_code = '0;
  logic [2:0] m_mem[8];
  bit         m_xfer = 1'b0;

  function automatic bit lit(int p);
    return (p % SLOT) < SC;
  endfunction

  function automatic int slot(int p);
    return (p / SLOT) % N;
  endfunction

  function automatic bit model_ready();
    return !m_on || !lit(m_pos) || (int'(wr_idx) != slot(m_pos));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    exp_t e;
    if (!rst_n) begin
      m_on = 1'b0;
      m_pos = 0;
      m_code = '0;
      m_xfer = 1'b0;
      foreach (m_mem[i]) m_mem[i] = '0;
      q.delete();
    end else begin
      m_xfer = wr_valid && model_ready();
      e.err = m_xfer && (int'(wr_idx) >= N);
      if (m_xfer && (int'(wr_idx) < N)) m_mem[wr_idx] = wr_data;
      e.fd = 1'b0;
      if (!en) begin
        m_on = 1'b0;
      end else if (!m_on) begin
        m_on = 1'b1;
        m_pos = 0;
      end else begin
        m_pos++;
        e.fd = (m_pos % FRAME) == 0;
      end
      if (m_on && (m_pos % SLOT) == 0) m_code = m_mem[slot(m_pos)];
      e.de = (m_on && lit(m_pos) && !blank_mask[slot(m_pos)]) ? 4'(1 << slot(m_pos)) : 4'd0;
      e.code = m_code;
      q.push_back(e);
    end
  end

  // Monitor: compare at the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_digit_en", 32'(digit_en), 0);
      chk("rst_code", 32'(code), 0);
      chk("rst_frame_done", 32'(frame_done), 0);
      chk("rst_wr_err", 32'(wr_err), 0);
      chk("rst_wr_ready", 32'(wr_ready), 0);
    end else begin
      chk("wr_ready", 32'(wr_ready), 32'(model_ready()));
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("digit_en", 32'(digit_en), 32'(e.de));
        chk("code", 32'(code), 32'(e.code));
        chk("frame_done", 32'(frame_done), 32'(e.fd));
        chk("wr_err", 32'(wr_err), 32'(e.err));
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input logic [2:0] i, input logic [2:0] d);
    wr_valid = 1'b1;
    wr_idx   = i;
    wr_data  = d;
    for (int k = 0; k < 200; k++) begin
      tick(1);
      if (m_xfer) begin
        wr_valid = 1'b0;
        return;
      end
    end
    wr_valid = 1'b0;
    timeout("write_handshake");
  endtask

  task automatic wait_lit(int s);
    for (int k = 0; k < 200; k++) begin
      if (m_on && lit(m_pos) && slot(m_pos) == s) return;
      tick(1);
    end
    timeout("wait_digit_lit");
  endtask

  initial begin
    bit pend;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Load codes while off, then scan two frames.
    do_write(3'd0, 3'd5);
    do_write(3'd1, 3'd2);
    do_write(3'd2, 3'd7);
    do_write(3'd3, 3'd1);
    en = 1'b1;
    tick(2 * FRAME);

    // Write to the lit digit must wait for its blank.
    wait_lit(1);
    do_write(3'd1, 3'd6);
    tick(FRAME + 5);

    blank_mask = 4'b0100;
    tick(2 * FRAME);
    blank_mask = '0;

    do_write(3'd5, 3'd3);
    tick(10);

    // Drop enable while digit 2 is lit, then restart.
    wait_lit(2);
    tick(1);
    en = 1'b0;
    tick(3);
    en = 1'b1;
    tick(FRAME + 3);

    // Randomised traffic.
    pend = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (pend && m_xfer) begin
        pend = 1'b0;
        wr_valid = 1'b0;
      end
      if (!pend && $urandom_range(0, 3) == 0) begin
        pend = 1'b1;
        wr_valid = 1'b1;
        wr_idx = 3'($urandom_range(0, 7));
        wr_data = 3'($urandom);
      end
      en = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 19) == 0) blank_mask = 4'($urandom);
      tick(1);
    end
    en = 1'b1;
    if (pend) begin
      for (int k = 0; k < 100 && !m_xfer; k++) tick(1);
      if (!m_xfer) timeout("random_write_drain");
    end
    wr_valid = 1'b0;
    blank_mask = '0;
    tick(FRAME);

    // Asynchronous reset mid-scan clears everything including codes.
    wait_lit(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_digit_en", 32'(digit_en), 0);
    chk("async_rst_code", 32'(code), 0);
    tick(2);
    rst_n = 1'b1;
    tick(FRAME + 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
